// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle through a single WIDTH+1-bit subtractor.
// Define DIVIDER_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up at FIN).
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;

  // Partial remainder stays below the divisor, so bit WIDTH of trial is a valid sign bit.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

`ifdef DIVIDER_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  assign dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
  assign quo_res = neg_quo_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
  assign rem_res = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;

  always_comb begin
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (state_q == IDLE && start) begin
      neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem_d = dividend[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign quo_res = dvd_q;
  assign rem_res = rem_q;
`endif

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    cnt_d         = cnt_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    done_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = '0;
          cnt_d = '0;
          dvs_d = dvs_mag;
          if (divisor == '0) begin
            // Raw dividend is kept so the zero-divisor result returns it unmodified.
            dvd_d   = dividend;
            dbz_d   = 1'b1;
            state_d = FIN;
          end else begin
            dvd_d   = dvd_mag;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d        = 1'b1;
        div_by_zero_d = dbz_q;
        if (dbz_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q;
        end else begin
          quotient_d  = quo_res;
          remainder_d = rem_res;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      cnt_q         <= '0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      cnt_q         <= cnt_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      done_q        <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: randomized operations against an arithmetic reference model.
module tb_seq_divider;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    int sa, sb, iq, ir;
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
      return;
    end
`ifdef DIVIDER_SIGNED_EN
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
`else
    sa = int'(a);
    sb = int'(b);
`endif
    iq = sa / sb;
    ir = sa % sb;
    q  = W'(iq);
    r  = W'(ir);
  endfunction

  // Drives one operation from idle and waits (bounded) for done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bsy, output bit timeout);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat      = 0;
    bsy      = busy ? 1 : 0;
    timeout  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (busy) bsy++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    total++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
    end
    total++;
    if ({quotient, remainder} !== '0) begin
      bad++; $display("FAIL reset_data: got q=%h r=%h expected 0 0", quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bsy; bit to;
    logic [W-1:0] eq, er; logic ez;
    model(4'd13, 4'd3, eq, er, ez);
    run_op(4'd13, 4'd3, lat, bsy, to);
    total++;
    if (to || lat != W + 1) begin
      bad++; $display("FAIL basic_latency: got %0d (timeout=%0d) expected %0d", lat, to, W + 1);
    end
    total++;
    if (bsy != W + 1) begin
      bad++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bsy, W + 1);
    end
    total++;
    if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
      bad++; $display("FAIL basic_result: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                      quotient, remainder, div_by_zero, eq, er, ez);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq || remainder !== er) begin
      bad++; $display("FAIL basic_hold: got done=%b busy=%b q=%h r=%h expected 0 0 %h %h",
                      done, busy, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_div_zero();
    int lat, bsy; bit to;
    run_op(4'd7, 4'd0, lat, bsy, to);
    total++;
    if (to || lat != 1) begin
      bad++; $display("FAIL dbz_latency: got %0d (timeout=%0d) expected 1", lat, to);
    end
    total++;
    if ({quotient, remainder, div_by_zero} !== {4'hF, 4'd7, 1'b1}) begin
      bad++; $display("FAIL dbz_result: got q=%h r=%h z=%b expected q=f r=7 z=1",
                      quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] as [5] = '{4'd15, 4'd2, 4'd0, 4'd15, 4'd1};
    logic [W-1:0] bs [5] = '{4'd1, 4'd15, 4'd5, 4'd15, 4'd0};
    int lat, bsy; bit to;
    logic [W-1:0] eq, er; logic ez;
    for (int i = 0; i < 5; i++) begin
      model(as[i], bs[i], eq, er, ez);
      run_op(as[i], bs[i], lat, bsy, to);
      total++;
      if (to || {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
        bad++; $display("FAIL boundary_%0d: %h/%h got q=%h r=%h z=%b to=%0d expected q=%h r=%h z=%b",
                        i, as[i], bs[i], quotient, remainder, div_by_zero, to, eq, er, ez);
      end
    end
  endtask

  task automatic test_random();
    int lat, bsy; bit to;
    logic [W-1:0] a, b, eq, er; logic ez;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      model(a, b, eq, er, ez);
      run_op(a, b, lat, bsy, to);
      total++;
      if (to || lat != (ez ? 1 : W + 1) ||
          {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
        bad++; $display("FAIL random_%0d: %h/%h got q=%h r=%h z=%b lat=%0d expected q=%h r=%h z=%b lat=%0d",
                        i, a, b, quotient, remainder, div_by_zero, lat, eq, er, ez, ez ? 1 : W + 1);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int done_at = -1;
    logic [W-1:0] gq = '0, gr = '0;
    logic [W-1:0] eq, er; logic ez;
    model(4'd13, 4'd3, eq, er, ez);
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= W + 6; c++) begin
      if (c == 3) begin
        dividend = 4'd9; divisor = 4'd2; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        dones++;
        done_at = c;
        gq = quotient;
        gr = remainder;
      end
    end
    total++;
    if (dones != 1 || done_at != W + 1) begin
      bad++; $display("FAIL ignore_done: got %0d pulses at %0d expected 1 at %0d", dones, done_at, W + 1);
    end
    total++;
    if (gq !== eq || gr !== er) begin
      bad++; $display("FAIL ignore_result: got q=%h r=%h expected q=%h r=%h", gq, gr, eq, er);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bsy; bit to;
    int dones = 0;
    logic [W-1:0] eq, er; logic ez;
    run_op(4'd14, 4'd3, lat, bsy, to);
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, div_by_zero} !== 3'b000 || {quotient, remainder} !== '0 || dones != 0) begin
      bad++; $display("FAIL abort_clear: got busy=%b done=%b z=%b q=%h r=%h early_done=%0d expected all 0",
                      busy, done, div_by_zero, quotient, remainder, dones);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
    model(4'd9, 4'd2, eq, er, ez);
    run_op(4'd9, 4'd2, lat, bsy, to);
    total++;
    if (to || {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
      bad++; $display("FAIL abort_recover: got q=%h r=%h z=%b to=%0d expected q=%h r=%h z=%b",
                      quotient, remainder, div_by_zero, to, eq, er, ez);
    end
  endtask

  task automatic test_back_to_back();
    int idx [$];
    int wrong = 0;
    logic [W-1:0] eq, er; logic ez;
    model(4'd11, 4'd2, eq, er, ez);
    @(negedge clk);
    dividend = 4'd11; divisor = 4'd2; start = 1'b1;
    for (int c = 0; c < 3 * (W + 2) + 2; c++) begin
      @(posedge clk); #1;
      if (done) begin
        idx.push_back(c);
        if (quotient !== eq || remainder !== er) wrong++;
      end
    end
    start = 1'b0;
    total++;
    if (idx.size() < 2 || idx[1] - idx[0] != W + 2) begin
      bad++; $display("FAIL b2b_period: got %0d pulses spacing %0d expected spacing %0d",
                      idx.size(), (idx.size() < 2) ? -1 : idx[1] - idx[0], W + 2);
    end
    total++;
    if (wrong != 0) begin
      bad++; $display("FAIL b2b_result: got %0d wrong results expected 0 (q=%h r=%h)", wrong, eq, er);
    end
    repeat (2 * (W + 2)) @(posedge clk);
    #1;
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    logic [W-1:0] as [3] = '{4'h9, 4'h7, 4'h8};
    logic [W-1:0] bs [3] = '{4'h2, 4'hE, 4'hF};
    logic [W-1:0] qs [3] = '{4'hD, 4'hD, 4'h8};
    logic [W-1:0] rs [3] = '{4'hF, 4'h1, 4'h0};
    int lat, bsy; bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(as[i], bs[i], lat, bsy, to);
      total++;
      if (to || lat != W + 1 || {quotient, remainder, div_by_zero} !== {qs[i], rs[i], 1'b0}) begin
        bad++; $display("FAIL signed_%0d: %h/%h got q=%h r=%h z=%b lat=%0d expected q=%h r=%h z=0 lat=%0d",
                        i, as[i], bs[i], quotient, remainder, div_by_zero, lat, qs[i], rs[i], W + 1);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_boundary();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
